// File: rtl/sdm_seq_if.sv
// Sample-source and modulator-side signals of the sigma-delta sequencer.
interface sdm_seq_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned Q_W    = 5
);
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [Q_W-1:0]    sdm_q;
  logic signed [DATA_W-1:0] sdm_data;
  logic                     sdm_rst;

  // Master: PCM source plus modulator feedback; slave: the sequencer.
  modport master (
    output in_data, in_valid, sdm_q,
    input  in_ready, sdm_data, sdm_rst
  );

  modport slave (
    input  in_data, in_valid, sdm_q,
    output in_ready, sdm_data, sdm_rst
  );
endinterface

// File: rtl/sdm_seq_ctrl.sv
// Sequencer in front of the CIFF sigma-delta modulator: zero-order hold of
// PCM samples over OSR clocks, soft mute/unmute gain ramp, and overload
// recovery that clears the modulator integrators and restarts with a ramp.
module sdm_seq_ctrl #(
  parameter int unsigned OSR         = 128,
  parameter int unsigned OVL_CNT     = 64,
  parameter int unsigned RECOVER_CYC = 16,
  parameter int unsigned GAIN_BITS   = 8
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            enable,
  input  logic            mute,
  sdm_seq_if.slave        bus,
  output logic            overload,
  output logic            underrun,
  output logic [2:0]      state
);

  localparam int unsigned DATA_W   = 24;
  localparam int unsigned Q_W      = 5;
  localparam int unsigned PH_W     = $clog2(OSR);
  localparam int unsigned OVL_W    = $clog2(OVL_CNT + 1);
  localparam int unsigned REC_W    = $clog2(RECOVER_CYC + 1);
  localparam int unsigned PROD_W   = DATA_W + GAIN_BITS + 1;
  localparam int unsigned GAIN_ONE = 1 << (GAIN_BITS - 1);

  localparam logic [PH_W-1:0]      PH_MAX   = PH_W'(OSR - 1);
  localparam logic [GAIN_BITS-1:0] GAIN_MAX = GAIN_BITS'(GAIN_ONE);
  localparam logic [GAIN_BITS-1:0] GAIN_PRE = GAIN_BITS'(GAIN_ONE - 1);
  localparam logic [OVL_W-1:0]     OVL_LAST = OVL_W'(OVL_CNT - 1);
  localparam logic [REC_W-1:0]     REC_LAST = REC_W'(RECOVER_CYC - 1);
  localparam logic [Q_W-1:0]       Q_POS_FS = {1'b0, {(Q_W-1){1'b1}}};
  localparam logic [Q_W-1:0]       Q_NEG_FS = {1'b1, {(Q_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_RUN       = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_MUTE      = 3'd4,
    S_RECOVER   = 3'd5
  } state_e;

  state_e                     state_q, state_d;
  logic [PH_W-1:0]            phase_q, phase_d;
  logic [GAIN_BITS-1:0]       gain_q, gain_d;
  logic signed [DATA_W-1:0]   hold_q, hold_d;
  logic signed [DATA_W-1:0]   sdm_data_q, sdm_data_d;
  logic                       sdm_rst_q, sdm_rst_d;
  logic                       in_ready_q, in_ready_d;
  logic                       overload_q, overload_d;
  logic                       underrun_q, underrun_d;
  logic [OVL_W-1:0]           ovl_cnt_q, ovl_cnt_d;
  logic [REC_W-1:0]           rec_cnt_q, rec_cnt_d;

  logic                       phase_last;
  logic                       q_full_scale;
  logic                       ovl_active;
  logic                       ovl_trip;
  logic signed [GAIN_BITS:0]  gain_ext;
  logic signed [PROD_W-1:0]   product;

  assign phase_last   = (phase_q == PH_MAX);
  assign q_full_scale = (bus.sdm_q == Q_POS_FS) || (bus.sdm_q == Q_NEG_FS);
  assign ovl_active   = (state_q == S_RAMP_UP) || (state_q == S_RUN) ||
                        (state_q == S_RAMP_DOWN);

  // Gain is unsigned; a zero sign bit makes the product a signed x unsigned multiply.
  assign gain_ext = {1'b0, gain_q};
  assign product  = PROD_W'(hold_q) * PROD_W'(gain_ext);

  // Sample slot capture, underrun detect and scaled output.
  always_comb begin
    hold_d     = hold_q;
    underrun_d = 1'b0;
    if (in_ready_q) begin
      if (bus.in_valid) begin
        hold_d = bus.in_data;
      end else begin
        underrun_d = 1'b1;
      end
    end
    sdm_data_d = DATA_W'(product >>> (GAIN_BITS - 1));
  end

  // Overload watchdog: run length of full-scale quantizer codes.
  always_comb begin
    ovl_cnt_d = '0;
    ovl_trip  = 1'b0;
    if (ovl_active && q_full_scale) begin
      if (ovl_cnt_q == OVL_LAST) begin
        ovl_trip = 1'b1;
      end else begin
        ovl_cnt_d = ovl_cnt_q + 1'b1;
      end
    end
  end

  // Next-state, gain ramp, modulator reset and phase/slot generation.
  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    sdm_rst_d  = sdm_rst_q;
    overload_d = overload_q;
    rec_cnt_d  = '0;
    phase_d    = phase_last ? '0 : phase_q + 1'b1;
    in_ready_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        gain_d    = '0;
        sdm_rst_d = 1'b1;
        if (enable) begin
          state_d   = S_RAMP_UP;
          sdm_rst_d = 1'b0;
        end
      end

      S_RAMP_UP: begin
        if (mute || !enable) begin
          state_d = S_RAMP_DOWN;
        end else if (gain_q >= GAIN_MAX) begin
          gain_d  = GAIN_MAX;
          state_d = S_RUN;
        end else if (phase_last) begin
          gain_d = gain_q + 1'b1;
          if (gain_q == GAIN_PRE) begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        gain_d = GAIN_MAX;
        if (mute || !enable) begin
          state_d = S_RAMP_DOWN;
        end
      end

      S_RAMP_DOWN: begin
        if (!mute && enable) begin
          state_d = S_RAMP_UP;
        end else if (gain_q == '0) begin
          state_d = enable ? S_MUTE : S_IDLE;
        end else if (phase_last) begin
          gain_d = gain_q - 1'b1;
          if (gain_q == GAIN_BITS'(1)) begin
            state_d = enable ? S_MUTE : S_IDLE;
          end
        end
      end

      S_MUTE: begin
        gain_d = '0;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (!mute) begin
          state_d = S_RAMP_UP;
        end
      end

      S_RECOVER: begin
        gain_d    = '0;
        sdm_rst_d = 1'b1;
        if (rec_cnt_q == REC_LAST) begin
          if (enable) begin
            state_d   = S_RAMP_UP;
            sdm_rst_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          rec_cnt_d = rec_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        gain_d    = '0;
        sdm_rst_d = 1'b1;
      end
    endcase

    // Overload wins over any mute/enable transition decided above.
    if (ovl_trip) begin
      state_d    = S_RECOVER;
      gain_d     = '0;
      sdm_rst_d  = 1'b1;
      overload_d = 1'b1;
      rec_cnt_d  = '0;
    end

    // Idle parks the phase at zero so a restart begins a full sample period.
    if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
      phase_d = '0;
    end
    if (state_d == S_IDLE) begin
      gain_d     = '0;
      sdm_rst_d  = 1'b1;
      overload_d = 1'b0;
    end

    in_ready_d = (phase_d == PH_MAX) &&
                 ((state_d == S_RAMP_UP) || (state_d == S_RUN) ||
                  (state_d == S_RAMP_DOWN) || (state_d == S_MUTE));
  end

  // State and output registers; reset returns everything to idle at once.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      gain_q     <= '0;
      hold_q     <= '0;
      sdm_data_q <= '0;
      sdm_rst_q  <= 1'b1;
      in_ready_q <= 1'b0;
      overload_q <= 1'b0;
      underrun_q <= 1'b0;
      ovl_cnt_q  <= '0;
      rec_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      gain_q     <= gain_d;
      hold_q     <= hold_d;
      sdm_data_q <= sdm_data_d;
      sdm_rst_q  <= sdm_rst_d;
      in_ready_q <= in_ready_d;
      overload_q <= overload_d;
      underrun_q <= underrun_d;
      ovl_cnt_q  <= ovl_cnt_d;
      rec_cnt_q  <= rec_cnt_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.sdm_data = sdm_data_q;
  assign bus.sdm_rst  = sdm_rst_q;
  assign overload     = overload_q;
  assign underrun     = underrun_q;
  assign state        = state_q;

endmodule

// File: tb/tb_sdm_seq_ctrl.sv
// Directed bench for sdm_seq_ctrl with a per-slot scoreboard of sdm_data.
module tb_sdm_seq_ctrl;

  localparam int unsigned OSR = 128;

  logic       clock = 1'b0;
  logic       rst;
  logic       enable;
  logic       mute;
  logic       overload;
  logic       underrun;
  logic [2:0] state;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  longint      last_cyc;
  bit          have_last;
  int          slot_no = 0;
  int          m_gain;
  logic [23:0] m_hold;
  logic [23:0] exp_q[$];

  sdm_seq_if bus ();

  sdm_seq_ctrl #(
    .OSR        (OSR),
    .OVL_CNT    (64),
    .RECOVER_CYC(16),
    .GAIN_BITS  (8)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .enable  (enable),
    .mute    (mute),
    .bus     (bus),
    .overload(overload),
    .underrun(underrun),
    .state   (state)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] u24(input logic [23:0] v);
    return {8'd0, v};
  endfunction

  // Reference scaling: signed sample times gain, divided by 128 with floor.
  function automatic logic [23:0] scale(input logic [23:0] h, input int g);
    longint p;
    p = longint'($signed(h)) * longint'(g);
    return 24'(p >>> 7);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for the next sample slot, offer a sample, and score the result.
  task automatic do_slot(input logic [23:0] data, input logic valid, input int dir);
    int          n;
    logic [23:0] e;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 3 * OSR) begin
      @(negedge clock);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("slot_wait", 32'(bus.in_ready), 32'd1);
      return;
    end
    if (have_last) check($sformatf("slot_period s%0d", slot_no), 32'(cyc - last_cyc), OSR);
    last_cyc  = cyc;
    have_last = 1'b1;
    bus.in_valid = valid;
    bus.in_data  = data;
    if (valid) m_hold = data;
    m_gain = m_gain + dir;
    if (m_gain < 0) m_gain = 0;
    if (m_gain > 128) m_gain = 128;
    exp_q.push_back(scale(m_hold, m_gain));
    @(negedge clock);
    bus.in_valid = 1'b0;
    check($sformatf("underrun s%0d", slot_no), 32'(underrun), 32'(!valid));
    @(negedge clock);
    e = exp_q.pop_front();
    check($sformatf("sdm_data s%0d", slot_no), u24(bus.sdm_data), u24(e));
    check($sformatf("underrun_once s%0d", slot_no), 32'(underrun), 32'd0);
    slot_no++;
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    enable       = 1'b0;
    mute         = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.sdm_q    = '0;
    m_gain       = 0;
    m_hold       = '0;
    have_last    = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_sdm_data", u24(bus.sdm_data), 32'd0);
    check("rst_sdm_rst", 32'(bus.sdm_rst), 32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_overload", 32'(overload), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_state", 32'(state), 32'd0);

    rst = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_state", 32'(state), 32'd0);
    check("idle_sdm_rst", 32'(bus.sdm_rst), 32'd1);

    // Enable: ramp from gain 0 to unity over 128 samples.
    enable = 1'b1;
    @(negedge clock);
    check("rampup_entry", 32'(state), 32'd1);
    check("rampup_sdm_rst", 32'(bus.sdm_rst), 32'd0);
    for (int i = 0; i < 128; i++) do_slot(24'h100000, 1'b1, 1);
    check("run_state", 32'(state), 32'd2);
    check("run_data", u24(bus.sdm_data), 32'h100000);

    // Missed slot: one underrun pulse, output holds.
    do_slot(24'h123456, 1'b0, 0);
    do_slot(24'h7FFFFF, 1'b1, 0);
    check("pos_fs_unity", u24(bus.sdm_data), 32'h7FFFFF);
    do_slot(24'h100000, 1'b1, 0);

    // 63 full-scale codes then a mid code: no overload.
    for (int i = 0; i < 63; i++) begin
      bus.sdm_q = 5'b01111;
      @(negedge clock);
    end
    bus.sdm_q = 5'b00000;
    @(negedge clock);
    check("ovl63_state", 32'(state), 32'd2);
    check("ovl63_flag", 32'(overload), 32'd0);

    // 64 full-scale codes: overload and recovery.
    for (int i = 0; i < 64; i++) begin
      bus.sdm_q = 5'b10000;
      @(negedge clock);
      if (i == 62) check("ovl_pre_state", 32'(state), 32'd2);
    end
    bus.sdm_q = 5'b00000;
    check("ovl_state", 32'(state), 32'd5);
    check("ovl_flag", 32'(overload), 32'd1);
    n = 0;
    while (bus.sdm_rst === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("recover_len", 32'(n), 32'd16);
    check("recover_exit", 32'(state), 32'd1);
    check("recover_data", u24(bus.sdm_data), 32'd0);
    check("ovl_sticky", 32'(overload), 32'd1);
    m_gain    = 0;
    have_last = 1'b0;

    // Negative full scale at half gain keeps its sign.
    for (int i = 0; i < 64; i++) do_slot(24'h800000, 1'b1, 1);
    check("neg_half_gain", u24(bus.sdm_data), 32'hC00000);
    for (int i = 0; i < 64; i++) do_slot(24'h100000, 1'b1, 1);
    check("rerun_state", 32'(state), 32'd2);
    check("rerun_data", u24(bus.sdm_data), 32'h100000);

    // Soft mute down to zero, then unmute part way.
    mute = 1'b1;
    @(negedge clock);
    check("mute_rampdown", 32'(state), 32'd3);
    for (int i = 0; i < 128; i++) do_slot(24'h100000, 1'b1, -1);
    check("mute_state", 32'(state), 32'd4);
    check("mute_data", u24(bus.sdm_data), 32'd0);
    mute = 1'b0;
    @(negedge clock);
    check("unmute_state", 32'(state), 32'd1);
    for (int i = 0; i < 40; i++) do_slot(24'h100000, 1'b1, 1);
    check("gain40_data", u24(bus.sdm_data), 32'h050000);
    mute = 1'b1;
    @(negedge clock);
    check("down40_state", 32'(state), 32'd3);
    check("down40_ovl", 32'(overload), 32'd1);

    // Asynchronous reset in the middle of the ramp-down.
    rst = 1'b1;
    #1;
    check("arst_data", u24(bus.sdm_data), 32'd0);
    check("arst_sdm_rst", 32'(bus.sdm_rst), 32'd1);
    check("arst_state", 32'(state), 32'd0);
    check("arst_ovl", 32'(overload), 32'd0);
    enable = 1'b0;
    mute   = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    check("post_rst_state", 32'(state), 32'd0);

    // Restart ramps from gain 0 with an empty hold register.
    enable    = 1'b1;
    m_gain    = 0;
    m_hold    = '0;
    have_last = 1'b0;
    for (int i = 0; i < 3; i++) do_slot(24'h100000, 1'b1, 1);
    check("restart_data", u24(bus.sdm_data), 32'h006000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdm_seq_ctrl.md
Name: sdm_seq_ctrl

Overview:
- Sequencer and protection controller in front of the 3rd-order CIFF sigma-delta modulator (24-bit in, 5-bit out, OSR=128).
- Accepts PCM samples at fs over a valid/ready handshake and zero-order-holds each sample for OSR modulator clocks.
- Applies a soft mute/unmute gain ramp.
- Watches the 5-bit quantizer output for sustained clipping, and on overload resets the modulator integrators and restarts with a ramp.

Parameters:
- OSR, 128, modulator clocks per input sample; power of two, 8..256
- OVL_CNT, 64, consecutive full-scale quantizer codes that declare overload
- RECOVER_CYC, 16, clocks sdm_rst is held during recovery
- GAIN_BITS, 8, gain word width; unity = 2^(GAIN_BITS-1) = 128

Ports:
- clock, input, 1, modulator clock
- rst, input, 1, asynchronous active-high reset
- enable, input, 1, run request; low forces ramp-down then IDLE
- mute, input, 1, soft mute request
- in_data, input, 24, signed PCM sample
- in_valid, input, 1, in_data valid
- in_ready, output, 1, sample-slot strobe
- sdm_q, input, 5, signed modulator quantizer output (feedback)
- sdm_data, output, 24, signed scaled held sample to modulator DataIn
- sdm_rst, output, 1, active-high integrator clear to modulator
- overload, output, 1, sticky overload flag
- underrun, output, 1, one-cycle pulse: slot passed with no valid sample
- state, output, 3, current FSM state encoding

Behaviour:
- Reset: sdm_data=0, sdm_rst=1, in_ready=0, overload=0, underrun=0, gain=0, phase=0, hold=0, state=IDLE(0).
- Phase counter: counts 0..OSR-1, wraps; runs in every state except IDLE; cleared on entry to RAMP_UP from IDLE.
- Sample slot: in_ready=1 only when phase==OSR-1 and state is RAMP_UP, RUN, RAMP_DOWN or MUTE.
  - in_valid & in_ready: hold<=in_data.
  - in_ready & !in_valid: hold is kept, underrun pulses for 1 cycle.
  - in_valid outside the slot is ignored (no back-pressure beyond that).
- Gain datapath: product=hold*gain (signed x unsigned, 33-bit); sdm_data<=product>>>7, arithmetic shift, truncated to 24 bits. Registered, so sdm_data updates 1 clock after hold/gain change. gain=128 gives sdm_data==hold exactly.
- Gain ramp: gain changes by ±1 only at phase==OSR-1 (once per sample). Full ramp = 128 samples. Clamped to 0..128.
- FSM, with encodings IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, MUTE=4, RECOVER=5:
  - IDLE: sdm_rst=1, gain=0. enable=1 -> RAMP_UP, with sdm_rst deasserted the same edge.
  - RAMP_UP: gain++ per sample. gain==128 -> RUN. mute=1 or enable=0 -> RAMP_DOWN immediately (from current gain).
  - RUN: gain=128. mute=1 or enable=0 -> RAMP_DOWN.
  - RAMP_DOWN: gain-- per sample. gain==0 -> IDLE if enable=0, else MUTE. mute=0 and enable=1 -> RAMP_UP.
  - MUTE: gain=0, modulator running on zero. enable=0 -> IDLE. mute=0 -> RAMP_UP.
  - RECOVER: sdm_rst=1, gain=0, in_ready=0. Counts RECOVER_CYC clocks, then RAMP_UP if enable=1, else IDLE.
- Overload detect:
  - Counter increments on each clock with sdm_q==5'sb01111 or 5'sb10000; any other code clears it.
  - Active only in RAMP_UP/RUN/RAMP_DOWN.
  - Counter reaching OVL_CNT -> next state RECOVER, overload<=1, counter cleared.
  - Overload has priority over mute/enable transitions in the same cycle.
  - overload flag cleared only by rst or by entering IDLE.
- rst asserted mid-ramp or mid-RECOVER: immediate return to reset values; no partial ramp survives.

Test Plan:
- Reset, enable=1, mute=0, constant in_data=24'sh100000 every slot -> in_ready pulses every 128 clocks; gain reaches 128 after 128 samples; RUN; sdm_data==24'sh100000.
- In RUN, assert mute -> sdm_data steps down by 1/128 per sample over 128 samples to 0; state MUTE. Deassert mute -> ramps back to 24'sh100000.
- in_data=24'sh800000 at gain 64 -> sdm_data==24'shC00000 (sign preserved). in_data=24'sh7FFFFF at gain 128 -> 24'sh7FFFFF.
- Drop in_valid for one slot -> single underrun pulse at phase 127; sdm_data holds previous value.
- Force sdm_q=5'sb01111 for 64 clocks in RUN -> overload=1; sdm_rst high exactly 16 clocks; then RAMP_UP from gain 0. Same stimulus for 63 clocks then 5'sb00000 -> no overload.
- Assert rst during RAMP_DOWN at gain 40 -> sdm_data=0, sdm_rst=1, state=IDLE asynchronously; enable restarts ramp from gain 0.
